traffic_phase_controller: RTL and testbench
===========================================

Name: traffic_phase_controller

Overview:
- Parametrised multi-approach traffic-light sequencer; successor to the fixed 3-state single-light control unit.
- Drives NUM_APPROACHES signal heads from a shared tick timebase with timed green/yellow/all-red phases, demand-driven round-robin and green extension.
- Keeps a manual step mode, where the controller advances on a step pulse instead of timers.
- Sits between the timebase/sensor inputs and the light-output pads; output control word per approach is 100=Red, 010=Green, 001=Yellow, 000=dark.

Parameters:
- NUM_APPROACHES, 4, number of approaches (2..8).
- CNT_W, 8, phase-timer width; every *_TICKS value is in 1..2^CNT_W.
- GREEN_TICKS, 20, minimum green duration in ticks.
- YELLOW_TICKS, 4, yellow duration in ticks.
- ALLRED_TICKS, 2, all-red clearance duration in ticks.
- IDX_W, derived, max(1, $clog2(NUM_APPROACHES)).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle timebase enable.
- manual  in  1  1=manual step mode, 0=timed auto mode.
- step  in  1  manual advance pulse, sampled only when manual=1.
- req  in  NUM_APPROACHES  per-approach demand (level).
- cw_lights  out  3*NUM_APPROACHES  approach k in bits [3k+2:3k], {R,G,Y}.
- active_idx  out  IDX_W  approach currently owning (or last owning) green.
- phase  out  2  0=RST, 1=ALL_RED, 2=GREEN, 3=YELLOW.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset=1 at posedge): phase=RST, active_idx=NUM_APPROACHES-1, timer=0, all cw_lights=000. Reset mid-phase aborts immediately with no yellow.
- Outputs decode combinationally from registered state; there is no extra latency.
- In RST, all approaches are 000. In ALL_RED, all are 100. In GREEN/YELLOW, approach active_idx is 010/001 and all others are 100.
- RST -> ALL_RED on the next clock; the timer loads ALLRED_TICKS-1.
- Timer rules:
  - On each phase entry, load X_TICKS-1.
  - On tick with timer!=0, decrement.
  - "Expire" = tick && timer==0. A phase therefore lasts exactly X_TICKS ticks after entry.
  - The timer holds when tick=0.
- Auto mode (manual=0):
  - ALL_RED expire -> GREEN. New active_idx is the first k with req[k]=1, searching from active_idx+1 upward with wrap modulo NUM_APPROACHES. If req==0, use active_idx+1 mod N, giving a fixed cycle.
  - GREEN expire -> YELLOW, unless req[active_idx]=1 and no other req bit is set. In that case green is extended: the timer reloads GREEN_TICKS-1 and phase stays GREEN.
  - YELLOW expire -> ALL_RED.
- Manual mode (manual=1):
  - The timer is ignored for transitions but keeps counting.
  - step=1 advances ALL_RED->GREEN (same next-index rule), GREEN->YELLOW, YELLOW->ALL_RED, and reloads the timer for the new phase.
  - At most one transition per cycle; step held high advances once per cycle.
  - step is ignored in RST.
- Mode change takes effect the same cycle. Switching manual->auto mid-phase continues with the current timer value.
- Simultaneous tick-expire and step in manual mode: step governs and only one advance occurs.
- req is sampled only at the ALL_RED->GREEN decision and at GREEN expiry; changes at other times have no effect.
- Green is never shown on more than one approach. Every green is followed by yellow and then all-red before the next green.

Optional Feature:
- Macro PED_WALK_EN adds an input ped_req [NUM_APPROACHES-1:0] and an output walk [NUM_APPROACHES-1:0].
- ped_req pulses are latched per approach.
- While approach k is GREEN and its latch is set, walk[k]=1. The latch clears on entry to YELLOW for k.
- A set latch also counts as demand in the round-robin search and blocks green extension.
- Without the macro, the ports are absent and behaviour is as above.

Test Plan:
- Common setup: N=4, GREEN=4, YELLOW=2, ALLRED=1, tick=1 every cycle.
- Reset release, req=0 -> RST 1 cycle; ALL_RED 1 cycle; GREEN on approach 0 for 4 cycles (cw_lights=12'b100_100_100_010); YELLOW 2 cycles; ALL_RED; then approach 1, 2, 3, 0 in order.
- req=4'b0100 held, active_idx=0 -> next green goes to approach 2 with no other greens. Green extends every 4 cycles while only req[2]=1. Setting req[0]=1 causes YELLOW on the next expire.
- tick asserted every 3rd cycle -> GREEN lasts 4 ticks (about 12 cycles). Phase holds while tick=0.
- manual=1, tick=0, step pulses -> ALL_RED->GREEN->YELLOW->ALL_RED, one transition per pulse. Simultaneous step and expiring tick produce a single advance.
- reset=1 during GREEN on approach 2 -> cycle after, phase=RST, cw_lights=0, active_idx=3.
- PED_WALK_EN: ped_req[1] pulse during ALL_RED -> walk[1]=1 throughout approach 1 green, 0 in yellow. The latch is cleared and does not re-trigger.

Source files
------------

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: timebase/sensor inputs and light outputs of the phase controller.
// Optional PED_WALK_EN adds ped_req/walk.
interface traffic_phase_controller_if #(parameter int N = 4);
  localparam int IDX_W = N > 2 ? $clog2(N) : 1;
  logic tick, manual, step;
  logic [N-1:0] req;
  logic [3*N-1:0] cw_lights;
  logic [IDX_W-1:0] active_idx;
  logic [1:0] phase;
`ifdef PED_WALK_EN
  logic [N-1:0] ped_req, walk;
  modport master(output tick, manual, step, req, ped_req, input cw_lights, active_idx, phase, walk);
  modport slave(input tick, manual, step, req, ped_req, output cw_lights, active_idx, phase, walk);
`else
  modport master(output tick, manual, step, req, input cw_lights, active_idx, phase);
  modport slave(input tick, manual, step, req, output cw_lights, active_idx, phase);
`endif
endinterface

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: multi-approach light sequencer with demand round-robin, green extension and manual step.
// Optional PED_WALK_EN latches pedestrian requests and drives walk during the matching green.
module traffic_phase_controller #(
  parameter int NUM_APPROACHES = 4,
  parameter int CNT_W = 8,
  parameter int GREEN_TICKS = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2
) (
  input logic clk,
  input logic reset,
  traffic_phase_controller_if.slave bus
);
  localparam int N = NUM_APPROACHES;
  localparam int IDX_W = N > 2 ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] G_T = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_T = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_T = CNT_W'(ALLRED_TICKS - 1);
  typedef enum logic [1:0] {RST, ALL_RED, GREEN, YELLOW} phase_e;
  phase_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N-1:0] demand, sel;
  logic expire, extend, adv;
  assign sel = N'(1) << idx_q;
  assign expire = bus.tick && timer_q == '0;
  assign adv = bus.manual ? bus.step : expire;
`ifdef PED_WALK_EN
  logic [N-1:0] ped_q, ped_d;
  assign demand = bus.req | ped_q;
  assign extend = bus.req[idx_q] && (bus.req & ~sel) == '0 && ped_q == '0;
  assign ped_d = (ped_q | bus.ped_req) & ~((state_q == GREEN && state_d == YELLOW) ? sel : '0);
  assign bus.walk = state_q == GREEN ? ped_q & sel : '0;
  always_ff @(posedge clk)
    ped_q <= reset ? '0 : ped_d;
`else
  assign demand = bus.req;
  assign extend = bus.req[idx_q] && (bus.req & ~sel) == '0;
`endif
  // Scan farthest to nearest so the closest requester after idx_q wins; self is the last resort.
  always_comb begin
    nxt_idx = IDX_W'((int'(idx_q) + 1) % N);
    for (int i = N; i >= 1; i--)
      if (demand[(int'(idx_q) + i) % N]) nxt_idx = IDX_W'((int'(idx_q) + i) % N);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    timer_d = (bus.tick && timer_q != '0) ? timer_q - CNT_W'(1) : timer_q;
    case (state_q)
      RST: begin
        state_d = ALL_RED;
        timer_d = A_T;
      end
      ALL_RED: if (adv) begin
        state_d = GREEN;
        idx_d = nxt_idx;
        timer_d = G_T;
      end
      GREEN: if (adv && !bus.manual && extend) timer_d = G_T;
        else if (adv) begin
          state_d = YELLOW;
          timer_d = Y_T;
        end
      YELLOW: if (adv) begin
        state_d = ALL_RED;
        timer_d = A_T;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= RST;
      idx_q <= IDX_W'(N - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
    end
  always_comb begin
    bus.cw_lights = '0;
    for (int k = 0; k < N; k++)
      bus.cw_lights[3*k +: 3] = state_q == RST ? 3'b000 :
                                (state_q == ALL_RED || k != int'(idx_q)) ? 3'b100 :
                                state_q == GREEN ? 3'b010 : 3'b001;
  end
  assign bus.phase = state_q;
  assign bus.active_idx = idx_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed cycle vectors pushed to a scoreboard queue, checked by a negedge monitor.
module tb_traffic_phase_controller;
  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] idx;
    logic [3:0] walk;
  } exp_t;
  localparam logic [1:0] RST = 2'd0, AR = 2'd1, G = 2'd2, Y = 2'd3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] exp_walk = '0;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  traffic_phase_controller_if #(.N(4)) bus();

  traffic_phase_controller #(
    .NUM_APPROACHES(4), .CNT_W(8), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lights(logic [1:0] ph, logic [1:0] idx);
    lights = '0;
    for (int k = 0; k < 4; k++)
      lights[3*k +: 3] = ph == RST ? 3'b000 :
                         (ph == G && k == int'(idx)) ? 3'b010 :
                         (ph == Y && k == int'(idx)) ? 3'b001 : 3'b100;
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  // One entry per clock: the registered state expected after that edge.
  task automatic push_n(int n, logic [1:0] ph, int idx);
    exp_t x;
    repeat (n) begin
      @(posedge clk);
      #1;
      x.ph = ph;
      x.idx = 2'(idx);
      x.walk = exp_walk;
      q.push_back(x);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("phase", 12'(bus.phase), 12'(e.ph));
      chk("active_idx", 12'(bus.active_idx), 12'(e.idx));
      chk("cw_lights", bus.cw_lights, lights(e.ph, e.idx));
`ifdef PED_WALK_EN
      chk("walk", 12'(bus.walk), 12'(e.walk));
`endif
    end

  initial begin
    bus.tick = 1'b1;
    bus.manual = 1'b0;
    bus.step = 1'b0;
    bus.req = '0;
`ifdef PED_WALK_EN
    bus.ped_req = '0;
`endif
    // reset and fixed round-robin with no demand
    push_n(1, RST, 3);
    reset = 1'b0;
    push_n(1, AR, 3);
    for (int k = 0; k < 5; k++) begin
      push_n(4, G, k % 4);
      push_n(2, Y, k % 4);
      push_n(1, AR, k % 4);
    end
    // demand skip and green extension
    bus.req = 4'b0100;
    push_n(8, G, 2);
    bus.req = 4'b0101;
    push_n(2, Y, 2);
    push_n(1, AR, 2);
    push_n(4, G, 0);
    bus.req = '0;
    push_n(2, Y, 0);
    push_n(1, AR, 0);
    // sparse tick: phases hold while tick=0
    bus.tick = 1'b0;
    push_n(2, AR, 0);
    bus.tick = 1'b1;
    push_n(1, G, 1);
    repeat (3) begin
      bus.tick = 1'b0;
      push_n(2, G, 1);
      bus.tick = 1'b1;
      push_n(1, G, 1);
    end
    bus.tick = 1'b0;
    push_n(2, G, 1);
    bus.tick = 1'b1;
    push_n(1, Y, 1);
    bus.tick = 1'b0;
    push_n(2, Y, 1);
    bus.tick = 1'b1;
    push_n(1, Y, 1);
    bus.tick = 1'b0;
    push_n(2, Y, 1);
    bus.tick = 1'b1;
    push_n(1, AR, 1);
    // manual stepping
    bus.manual = 1'b1;
    bus.tick = 1'b0;
    push_n(2, AR, 1);
    bus.step = 1'b1;
    push_n(1, G, 2);
    bus.step = 1'b0;
    push_n(3, G, 2);
    bus.step = 1'b1;
    push_n(1, Y, 2);
    bus.step = 1'b0;
    push_n(2, Y, 2);
    bus.step = 1'b1;
    push_n(1, AR, 2);
    bus.step = 1'b0;
    push_n(1, AR, 2);
    bus.step = 1'b1;
    push_n(1, G, 3);
    push_n(1, Y, 3);
    push_n(1, AR, 3);
    bus.tick = 1'b1;
    push_n(1, G, 0);
    bus.step = 1'b0;
    push_n(5, G, 0);
    // back to auto: the already-expired timer moves on at once
    bus.manual = 1'b0;
    push_n(2, Y, 0);
    push_n(1, AR, 0);
    // reset in the middle of a green
    push_n(4, G, 1);
    push_n(2, Y, 1);
    push_n(1, AR, 1);
    push_n(2, G, 2);
    reset = 1'b1;
    push_n(1, RST, 3);
    reset = 1'b0;
    push_n(1, AR, 3);
    push_n(1, G, 0);
`ifdef PED_WALK_EN
    push_n(3, G, 0);
    push_n(2, Y, 0);
    push_n(1, AR, 0);
    bus.ped_req = 4'b0010;
    exp_walk = 4'b0010;
    push_n(1, G, 1);
    bus.ped_req = '0;
    push_n(3, G, 1);
    exp_walk = '0;
    push_n(2, Y, 1);
    push_n(1, AR, 1);
    for (int k = 2; k < 6; k++) begin
      push_n(4, G, k % 4);
      push_n(2, Y, k % 4);
      push_n(1, AR, k % 4);
    end
`endif
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
